calc_datapath: RTL and testbench
================================

Name: calc_datapath

Overview:
- Datapath stage of the small calculator. It sits directly downstream of control_unit and consumes its s1, WA, WE, RAA, RAB, REA, REB, C and s2 controls.
- Contains an input mux (MUX1), a 4-entry register file, a 2-bit-opcode ALU, an output mux (MUX2) and a registered result output that drives the display/LED logic.
- Operands come from two external switch inputs; results can be written back to the register file.

Parameters:
- W, 4, data width of operands, registers, ALU and result.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in1  in  W  external operand 1 (switches)
- in2  in  W  external operand 2 (switches)
- s1  in  2  MUX1 select: 0=in1, 1=in2, 2=alu_y, 3=zero
- WA  in  2  register-file write address
- WE  in  1  register-file write enable
- RAA  in  2  read address, port A
- RAB  in  2  read address, port B
- REA  in  1  read enable A; 0 forces operand A to 0
- REB  in  1  read enable B; 0 forces operand B to 0
- C  in  2  ALU op: 0=A+B, 1=A-B, 2=A&B, 3=A^B
- s2  in  1  MUX2 select: 1 loads result register from alu_y, 0 holds it
- out  out  W  registered calculator result
- zf  out  1  zero flag (optional feature)
- cf  out  1  carry/borrow flag (optional feature)

Behaviour:
- Reset, synchronous, rst=1 at a rising edge:
  - All four registers R0..R3 are cleared to 0.
  - out, zf and cf are cleared to 0.
  - Reset takes priority over WE and s2 in the same cycle, including in the middle of an operation.
- Register file:
  - Reads are combinational: A = REA ? R[RAA] : 0, and B = REB ? R[RAB] : 0.
  - Write at a rising edge when WE=1: R[WA] is loaded with the MUX1 output.
  - Read-during-write to the same address returns the old value in that cycle. The new value is visible the following cycle. There is no bypass.
- MUX1: purely combinational. s1=2 feeds alu_y back into the file (A op B is computed and stored in the same cycle). s1=3 writes 0.
- ALU: combinational, W-bit, modulo 2^W.
  - Add: alu_y = (A+B)[W-1:0]; carry = bit W of the W+1-bit sum.
  - Sub: alu_y = (A-B)[W-1:0]; borrow = 1 when A<B, unsigned.
  - AND/XOR: carry = 0.
- Output register:
  - At a rising edge with s2=1 and rst=0, out is loaded with alu_y.
  - With s2=0, out holds its value.
  - Latency: one clock from a stable control word to out.
- Simultaneous events: WE=1 and s2=1 in the same cycle are legal. Both the register write and the out load use values computed from the pre-edge register contents.
- No internal FSM. Sequencing belongs to control_unit. The datapath must tolerate any control value on any cycle, so there are no illegal codes.
- Unused read port (REx=0) must not affect the result beyond supplying 0.

Optional Feature:
- Macro CALC_FLAGS_EN.
- Defined:
  - zf and cf are registers, loaded together with out when s2=1.
  - zf = (alu_y==0).
  - cf = carry for add, borrow for sub, 0 for AND/XOR.
  - Both are cleared by rst.
- Undefined:
  - zf and cf ports still exist but are tied constantly to 0.
  - No flag flops are synthesized.

Test Plan:
- Load and add:
  - Stimulus: rst pulse; then s1=0, in1=3, WA=0, WE=1; then s1=1, in2=5, WA=1, WE=1; then RAA=0, RAB=1, REA=REB=1, C=0, s2=1.
  - Response: out=8 one clock later; R0=3, R1=5; with CALC_FLAGS_EN, zf=0 and cf=0.
- Subtract wrap:
  - Stimulus: R0=3, R1=5; C=1, RAA=0, RAB=1, s2=1.
  - Response: out=14 (4'hE); cf=1 when CALC_FLAGS_EN is defined.
- Logic ops and zero:
  - Stimulus: R0=4'hA, R1=4'hA; C=3, then C=2.
  - Response: out=0 with zf=1 (flags on); then out=4'hA with zf=0.
- Write-back and read-during-write:
  - Stimulus: s1=2, C=0, WA=2, WE=1, RAA=RAB=2, R2=1.
  - Response: each clock R2 doubles (1,2,4,8,0 wrap), and every read returns the pre-edge value.
- Read enables and hold:
  - Stimulus: REA=0, REB=1, R1=5, C=1, s2=1; then s2=0 with in1/in2 toggling.
  - Response: out=(0-5) mod 16=11; out then holds 11 while s2=0.
- Reset mid-operation:
  - Stimulus: rst=1 in the same cycle as WE=1, s2=1.
  - Response: after that edge R0..R3=0, out=0, zf=cf=0, and no write occurred.

Source files
------------

// File: rtl/calc_datapath.sv
// Calculator datapath: input mux, 4-entry register file, 2-bit ALU and registered result.
// Optional registered zero/carry flags are enabled by defining CALC_FLAGS_EN.
module calc_datapath #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [1:0]   s1,
    input  logic [1:0]   WA,
    input  logic         WE,
    input  logic [1:0]   RAA,
    input  logic [1:0]   RAB,
    input  logic         REA,
    input  logic         REB,
    input  logic [1:0]   C,
    input  logic         s2,
    output logic [W-1:0] out,
    output logic         zf,
    output logic         cf
);

    logic [W-1:0] rf [4];
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] alu_y;
    logic [W-1:0] wr_data;

    function automatic logic [W-1:0] alu_res(input logic [1:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // Reads are combinational and see pre-edge contents; a disabled port yields 0.
    assign op_a  = REA ? rf[RAA] : '0;
    assign op_b  = REB ? rf[RAB] : '0;
    assign alu_y = alu_res(C, op_a, op_b);

    always_comb begin
        wr_data = '0;
        case (s1)
            2'd0:    wr_data = in1;
            2'd1:    wr_data = in2;
            2'd2:    wr_data = alu_y;
            default: wr_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
            out <= '0;
        end else begin
            if (WE) rf[WA] <= wr_data;
            if (s2) out <= alu_y;
        end
    end

`ifdef CALC_FLAGS_EN
    // Carry of the add and borrow of the subtract both appear as bit W of a W+1-bit result.
    function automatic logic alu_carry(input logic [1:0] op,
                                       input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        logic [W:0] t;
        case (op)
            2'd0:    t = {1'b0, a} + {1'b0, b};
            2'd1:    t = {1'b0, a} - {1'b0, b};
            default: t = '0;
        endcase
        return t[W];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            zf <= 1'b0;
            cf <= 1'b0;
        end else if (s2) begin
            zf <= (alu_y == '0);
            cf <= alu_carry(C, op_a, op_b);
        end
    end
`else
    assign zf = 1'b0;
    assign cf = 1'b0;
`endif

endmodule

// File: tb/tb_calc_datapath.sv
// Self-checking bench for calc_datapath: directed test-plan steps then random control words
// compared against a behavioural model of the calculator.
module tb_calc_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in1, in2;
    logic [1:0] s1, wa, raa, rab, c;
    logic       we, rea, reb, s2;
    logic [3:0] out;
    logic       zf, cf;

    int checks = 0;
    int fails  = 0;

    // Behavioural model state.
    int m_r[4];
    int m_out, m_zf, m_cf;

    calc_datapath #(.W(4)) dut (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .s1(s1), .WA(wa), .WE(we),
        .RAA(raa), .RAB(rab), .REA(rea), .REB(reb), .C(c), .s2(s2),
        .out(out), .zf(zf), .cf(cf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ctl(input int s1_v, input int wa_v, input int we_v, input int raa_v,
                       input int rab_v, input int rea_v, input int reb_v, input int c_v,
                       input int s2_v);
        s1 = 2'(s1_v); wa = 2'(wa_v); we = 1'(we_v); raa = 2'(raa_v); rab = 2'(rab_v);
        rea = 1'(rea_v); reb = 1'(reb_v); c = 2'(c_v); s2 = 1'(s2_v);
    endtask

    // Advance one clock, update the model from the pre-edge state, then compare outputs.
    task automatic tick(input string tag);
        int a, b, y, cy, wd;
        a = rea ? m_r[raa] : 0;
        b = reb ? m_r[rab] : 0;
        cy = 0;
        case (c)
            2'd0: begin y = (a + b) % 16; cy = (a + b > 15) ? 1 : 0; end
            2'd1: begin y = (a - b + 16) % 16; cy = (a < b) ? 1 : 0; end
            2'd2: y = a & b;
            default: y = a ^ b;
        endcase
        case (s1)
            2'd0: wd = in1;
            2'd1: wd = in2;
            2'd2: wd = y;
            default: wd = 0;
        endcase
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) m_r[i] = 0;
            m_out = 0; m_zf = 0; m_cf = 0;
        end else begin
            if (we) m_r[wa] = wd;
            if (s2) begin
                m_out = y;
                m_zf = (y == 0) ? 1 : 0;
                m_cf = cy;
            end
        end
        #1;
        chk({tag, ".out"}, out, m_out);
`ifdef CALC_FLAGS_EN
        chk({tag, ".zf"}, zf, m_zf);
        chk({tag, ".cf"}, cf, m_cf);
`else
        chk({tag, ".zf"}, zf, 0);
        chk({tag, ".cf"}, cf, 0);
`endif
    endtask

    // Place R[idx] on out through A+0 and check it against an absolute value.
    task automatic peek(input string tag, input int idx, input int exp);
        ctl(0, 0, 0, idx, 0, 1, 0, 0, 1);
        tick(tag);
        chk({tag, ".abs"}, out, exp);
    endtask

    initial begin
        in1 = 4'd0; in2 = 4'd0;
        ctl(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick("reset");
        chk("reset.abs", out, 0);
        rst = 1'b0;

        // Load and add.
        in1 = 4'd3; ctl(0, 0, 1, 0, 0, 0, 0, 0, 0); tick("load_r0");
        in2 = 4'd5; ctl(1, 1, 1, 0, 0, 0, 0, 0, 0); tick("load_r1");
        ctl(0, 0, 0, 0, 1, 1, 1, 0, 1); tick("add");
        chk("add.abs", out, 8);
        peek("r0", 0, 3);
        peek("r1", 1, 5);

        // Subtract wrap.
        ctl(0, 0, 0, 0, 1, 1, 1, 1, 1); tick("sub_wrap");
        chk("sub_wrap.abs", out, 14);
`ifdef CALC_FLAGS_EN
        chk("sub_wrap.cf_abs", cf, 1);
`endif

        // Logic ops and zero.
        in1 = 4'hA; ctl(0, 0, 1, 0, 0, 0, 0, 0, 0); tick("load_a0");
        ctl(0, 1, 1, 0, 0, 0, 0, 0, 0); tick("load_a1");
        ctl(0, 0, 0, 0, 1, 1, 1, 3, 1); tick("xor");
        chk("xor.abs", out, 0);
        ctl(0, 0, 0, 0, 1, 1, 1, 2, 1); tick("and");
        chk("and.abs", out, 10);

        // Write-back with read-during-write: R2 doubles each clock.
        in1 = 4'd1; ctl(0, 2, 1, 0, 0, 0, 0, 0, 0); tick("load_r2");
        ctl(2, 2, 1, 2, 2, 1, 1, 0, 1);
        tick("dbl1"); chk("dbl1.abs", out, 2);
        tick("dbl2"); chk("dbl2.abs", out, 4);
        tick("dbl3"); chk("dbl3.abs", out, 8);
        tick("dbl4"); chk("dbl4.abs", out, 0);
        peek("r2_wrap", 2, 0);

        // Read enables and hold.
        in1 = 4'd5; ctl(0, 1, 1, 0, 0, 0, 0, 0, 0); tick("load_r1b");
        ctl(0, 0, 0, 0, 1, 0, 1, 1, 1); tick("rea_off");
        chk("rea_off.abs", out, 11);
        ctl(0, 0, 0, 0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            in1 = 4'($urandom); in2 = 4'($urandom);
            tick("hold");
            chk("hold.abs", out, 11);
        end

        // Reset mid-operation: write and load requested in the same cycle as reset.
        in1 = 4'd7; ctl(0, 3, 1, 1, 1, 1, 1, 0, 1);
        rst = 1'b1;
        tick("rst_mid");
        chk("rst_mid.abs", out, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) peek("rst_reg", i, 0);

        // Random control words, with occasional reset.
        for (int n = 0; n < 400; n++) begin
            in1 = 4'($urandom); in2 = 4'($urandom);
            ctl($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
            rst = ($urandom_range(0, 31) == 0);
            tick("rand");
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
